load_store_unit: RTL and testbench

Sits between the RV32 core's execute stage and the byte-addressed data RAM.
- Accepts one load/store request per handshake and checks it.
- Drives the RAM's 3-bit write-enable and address.
- Extracts and sign- or zero-extends load data.
- Returns a registered response with an error code.
- RAM byte order: the byte at addr is data_out[31:24] (big-endian within the 32-bit word).

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/lsu_load_extend.sv | 30 +++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RISC-V funct3 encodings for loads and stores
//   - RAM write-enable encodings (one-hot by access size)
//   - response error codes
//   - FSM state enum
//   - helper that classifies a funct3 as a legal load or store
// ---------------------------------------------------------------------------
package lsu_pkg;

    // funct3 encodings (size in [1:0], unsigned flag in [2])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // RAM write-enable encodings
    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_WORD = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_BYTE = 3'b100;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

    // Loads allow B/H/W/BU/HU; stores only B/H/W.
    function automatic logic legal_op(input logic store, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (store) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

    // Number of bytes touched minus one, from funct3[1:0].
    function automatic logic [2:0] size_minus_one(input logic [2:0] funct3);
        logic [2:0] s;
        case (funct3[1:0])
            2'b00:   s = 3'd0;
            2'b01:   s = 3'd1;
            2'b10:   s = 3'd3;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// ---------------------------------------------------------------------------
// lsu_load_extend
// Combinational load-data extraction. The RAM is big-endian within the word,
// so the addressed byte/half always sits at the top of mem_rdata.
// Ports:
//   funct3    in  3   load type (LB/LH/LW/LBU/LHU)
//   mem_rdata in  32  raw RAM read data
//   ext_data  out 32  sign- or zero-extended result
// ---------------------------------------------------------------------------
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = mem_rdata;
        case (funct3)
            F3_B:    ext_data = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
            F3_H:    ext_data = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
            F3_W:    ext_data = mem_rdata;
            F3_BU:   ext_data = {24'h000000, mem_rdata[31:24]};
            F3_HU:   ext_data = {16'h0000, mem_rdata[31:16]};
            default: ext_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bridges the RV32 execute stage to a byte-addressed data RAM. One request is
// accepted in IDLE, the RAM is accessed for exactly one ACCESS cycle, and the
// registered response is held in RESP until the consumer takes it.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned half and
// word accesses with error 01. Without it misaligned accesses proceed.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_store               1 = store, 0 = load
//   req_funct3              RISC-V funct3
//   req_addr   [ADDR_W]     byte address
//   req_wdata  [32]         right-aligned store data
//   resp_valid/resp_ready   response handshake
//   resp_rdata [32]         extended load data (0 for stores / errors)
//   resp_err   [2]          00 ok, 01 misaligned, 10 range, 11 illegal
//   mem_we     [3]          001 word, 010 half, 100 byte, 000 none
//   mem_addr   [32]         RAM address
//   mem_wdata  [32]         RAM write data
//   mem_rdata  [32]         RAM combinational read data
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 2048,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic [2:0]        mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e state, state_next;

    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        err_q;
    logic [31:0]       rdata_q;

    logic [1:0]        req_err;
    logic [ADDR_W:0]   last_byte;
    logic              out_of_range;
    logic              misaligned;
    logic [31:0]       ext_data;

    // Request checking. The end address is formed one bit wider than the
    // address so an access near the top of the address space cannot wrap
    // around to a small, in-range value.
    always_comb begin
        last_byte    = {1'b0, req_addr} + (ADDR_W+1)'(size_minus_one(req_funct3));
        out_of_range = (last_byte >= (ADDR_W+1)'(MEM_BYTES));
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misaligned   = 1'b0;
`endif
        // Priority: illegal > misaligned > range
        if (!legal_op(req_store, req_funct3)) begin
            req_err = ERR_ILLEGAL;
        end else if (misaligned) begin
            req_err = ERR_MISALIGN;
        end else if (out_of_range) begin
            req_err = ERR_RANGE;
        end else begin
            req_err = ERR_OK;
        end
    end

    lsu_load_extend u_load_extend (
        .funct3    (funct3_q),
        .mem_rdata (mem_rdata),
        .ext_data  (ext_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state. mem_we depends only on state and latched
    // request fields, so it drops together with the asynchronous state reset.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_we     = WE_NONE;
        if ((state == ACCESS) && store_q && (err_q == ERR_OK)) begin
            case (funct3_q[1:0])
                2'b00:   mem_we = WE_BYTE;
                2'b01:   mem_we = WE_HALF;
                2'b10:   mem_we = WE_WORD;
                default: mem_we = WE_NONE;
            endcase
        end
    end

    // Request latch and response data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= ERR_OK;
            rdata_q  <= 32'h0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            // Stores and errored requests return zero data.
            if (state == ACCESS) begin
                rdata_q <= (!store_q && (err_q == ERR_OK)) ? ext_data : 32'h0;
            end
        end
    end

    assign mem_addr   = 32'(addr_q);
    assign mem_wdata  = wdata_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int MEM_BYTES = 2048;
    localparam int ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic [2:0]        mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- big-endian byte RAM model ----------------
    logic [7:0] ram [0:MEM_BYTES-1];
    logic       ram_clear = 1'b1;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a < MEM_BYTES) return ram[a[10:0]];
        return 8'h00;
    endfunction

    assign mem_rdata = {rd_byte(mem_addr), rd_byte(mem_addr + 32'd1),
                        rd_byte(mem_addr + 32'd2), rd_byte(mem_addr + 32'd3)};

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < MEM_BYTES; i++) ram[i] <= 8'h00;
        end else begin
            case (mem_we)
                3'b100: if (mem_addr < MEM_BYTES) ram[mem_addr[10:0]] <= mem_wdata[7:0];
                3'b010: begin
                    for (int i = 0; i < 2; i++)
                        if (mem_addr + i < MEM_BYTES)
                            ram[10'(0) + 11'(mem_addr + i)] <= mem_wdata[8*(1-i) +: 8];
                end
                3'b001: begin
                    for (int i = 0; i < 4; i++)
                        if (mem_addr + i < MEM_BYTES)
                            ram[10'(0) + 11'(mem_addr + i)] <= mem_wdata[8*(3-i) +: 8];
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        string       name;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_resp  = 0;
    int    we_cycles = 0;
    logic [2:0] last_we = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic [1:0] err, input string name);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    // Response monitor: pops one expectation per completed handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata %h err %0d, expected none", resp_rdata, resp_err);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
                check({mon_e.name, "_err"}, {30'h0, resp_err}, {30'h0, mon_e.err});
            end
            n_resp++;
        end
    end

    // Write-enable observer
    always @(negedge clk) begin
        if (mem_we != 3'b000) begin
            we_cycles++;
            last_we = mem_we;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accept(input string name, output bit ok);
        int k;
        k = 0;
        ok = 1'b0;
        while (k < 30) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            k++;
        end
        if (!ok) timeout_fail({name, "_accept"});
    endtask

    task automatic wait_resp_count(input int target, input string name);
        int k;
        k = 0;
        while (n_resp < target && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (n_resp < target) timeout_fail({name, "_resp"});
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic [1:0] exp_err, input logic [2:0] exp_we,
                          input string name);
        int  start;
        bit  ok;
        push_exp(exp_rd, exp_err, name);
        start      = n_resp;
        we_cycles  = 0;
        last_we    = 3'b000;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        wait_accept(name, ok);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (ok) begin
            wait_resp_count(start + 1, name);
            check({name, "_we_cycles"}, 32'(we_cycles), (exp_we != 3'b000) ? 32'd1 : 32'd0);
            check({name, "_we"}, {29'h0, last_we}, {29'h0, exp_we});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  start;
        int  k;
        bit  ok;
        logic [1:0]  mis_err;
        logic [31:0] mis_rd;
        logic [1:0]  wrap_err;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'h0, req_ready},  32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err",   {30'h0, resp_err},   32'd0);
        check("rst_mem_we",     {29'h0, mem_we},     32'd0);
        check("rst_mem_addr",   mem_addr,  32'h0);
        check("rst_mem_wdata",  mem_wdata, 32'h0);
        ram_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store / load
        do_req(1'b1, 3'b010, 32'h010, 32'h11223344, 32'h0,        2'b00, 3'b001, "sw_010");
        do_req(1'b0, 3'b010, 32'h010, 32'h0,        32'h11223344, 2'b00, 3'b000, "lw_010");
        // Byte / half extraction
        do_req(1'b1, 3'b000, 32'h020, 32'h00000080, 32'h0,        2'b00, 3'b100, "sb_020");
        do_req(1'b0, 3'b000, 32'h020, 32'h0,        32'hFFFFFF80, 2'b00, 3'b000, "lb_020");
        do_req(1'b0, 3'b100, 32'h020, 32'h0,        32'h00000080, 2'b00, 3'b000, "lbu_020");
        do_req(1'b1, 3'b001, 32'h030, 32'h0000BEEF, 32'h0,        2'b00, 3'b010, "sh_030");
        do_req(1'b0, 3'b001, 32'h030, 32'h0,        32'hFFFFBEEF, 2'b00, 3'b000, "lh_030");
        do_req(1'b0, 3'b101, 32'h030, 32'h0,        32'h0000BEEF, 2'b00, 3'b000, "lhu_030");
        // Range
        do_req(1'b0, 3'b010, 32'h7FC, 32'h0,        32'h0,        2'b00, 3'b000, "lw_7fc");
        do_req(1'b0, 3'b010, 32'h7FE, 32'h0,        32'h0,        2'b10, 3'b000, "lw_7fe");
        do_req(1'b1, 3'b000, 32'h800, 32'h55,       32'h0,        2'b10, 3'b000, "sb_800");
`ifdef LSU_MISALIGN_CHECK_EN
        mis_err  = 2'b01;
        mis_rd   = 32'h0;
        wrap_err = 2'b01;
`else
        // Bytes 0x12..0x15 = 33 44 00 00
        mis_err  = 2'b00;
        mis_rd   = 32'h33440000;
        wrap_err = 2'b10;
`endif
        do_req(1'b0, 3'b010, 32'h012, 32'h0, mis_rd, mis_err, 3'b000, "lw_012");
        // Half at the very top of the address space must not wrap into range
        do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h0, wrap_err, 3'b000, "lh_top");
        // Illegal ops
        do_req(1'b0, 3'b011, 32'h010, 32'h0,        32'h0, 2'b11, 3'b000, "ld_f3_011");
        do_req(1'b1, 3'b100, 32'h010, 32'hCAFEF00D, 32'h0, 2'b11, 3'b000, "st_f3_100");
        do_req(1'b0, 3'b010, 32'h010, 32'h0, 32'h11223344, 2'b00, 3'b000, "lw_010_again");

        // Backpressure with a second request held on the input
        start = n_resp;
        resp_ready = 1'b0;
        push_exp(32'h11223344, 2'b00, "bp_lw");
        push_exp(32'h00000080, 2'b00, "bp_lbu");
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h010;
        req_wdata  = 32'h0;
        wait_accept("bp_first", ok);
        @(posedge clk);
        #1;
        req_funct3 = 3'b100;
        req_addr   = 32'h020;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!resp_valid) timeout_fail("bp_resp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'h0, resp_valid}, 32'd1);
            check("bp_hold_rdata", resp_rdata, 32'h11223344);
            check("bp_hold_err",   {30'h0, resp_err}, 32'd0);
            check("bp_hold_ready", {31'h0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_accept("bp_second", ok);
        check("bp_second_after_handshake", 32'(n_resp - start), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp_count(start + 2, "bp_second");

        // Reset during ACCESS of a store
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h040;
        req_wdata  = 32'hDEADBEEF;
        wait_accept("rst_sw", ok);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_sw_access_we", {29'h0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_we",         {29'h0, mem_we},     32'd0);
        check("rst_async_resp_valid", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rel_req_ready",  {31'h0, req_ready},  32'd1);
        check("rst_rel_resp_valid", {31'h0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rel_resp_valid_later", {31'h0, resp_valid}, 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
